qpp_ind_gen: RTL and testbench
==============================

# qpp_ind_gen

Parametrised index generator for the turbo-coder interleaver path. On a start request it latches a block length K and the QPP coefficients f1/f2, then streams every natural index i = 0..K-1 alongside its interleaved index pi(i) = (f1·i + f2·i²) mod K, under a valid/ready handshake. It sits between the code-block segmentation control and the interleaver memory address ports. It replaces the fixed two-size sequential counter with run-time K, QPP address computation, downstream backpressure, abort and configuration checking.

## Interface
- ADDR_W, 14, width of K, f1, f2 and both index outputs
- MAX_K, 6144, largest accepted block length (must be < 2^ADDR_W)
- MIN_K, 40, smallest accepted block length
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clock clock
- start  in  1  request a new block; sampled only in IDLE
- k_len  in  ADDR_W  block length K, sampled with start
- f1  in  ADDR_W  QPP coefficient f1, sampled with start
- f2  in  ADDR_W  QPP coefficient f2, sampled with start
- abort  in  1  synchronous cancel; return to IDLE, no done
- out_ready  in  1  downstream accepts the current index pair
- out_valid  out  1  seq_idx/ilv_idx/last are valid
- seq_idx  out  ADDR_W  natural index i
- ilv_idx  out  ADDR_W  interleaved index pi(i)
- last  out  1  high with the pair where i = K-1
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse after final pair accepted
- cfg_err  out  1  one-cycle pulse, start rejected

## Operation
- States: IDLE, RUN, DONE.
- IDLE: out_valid=0. On start=1: if MIN_K <= k_len <= MAX_K, f1 < k_len and f2 < k_len, latch K, f1, f2; set seq=0, pi=0, g=(f1+f2) mod K, d=(2·f2) mod K; go RUN. Otherwise pulse cfg_err one cycle, stay IDLE, latch nothing.
- RUN: out_valid=1, seq_idx=seq, ilv_idx=pi, last=(seq==K-1). On out_valid & out_ready: if last go DONE; else seq+=1, pi=(pi+g) mod K, g=(g+d) mod K. Without out_ready all outputs hold.
- DONE: done=1, out_valid=0 for one cycle; then IDLE.
- Recursion uses no multipliers: each mod K is one ADDR_W+1-bit add then conditional subtract of K (operands always < K, so sum < 2K).
- abort=1 in any state: next cycle IDLE, out_valid=0, no done; abort has priority over start and handshake.
- start in RUN/DONE ignored; coefficients are not re-sampled mid-block.
- K need not be a legal LTE size; any K/f1/f2 in range is computed exactly per the formula.

## Timing
- Reset values: out_valid=0, seq_idx=0, ilv_idx=0, last=0, busy=0, done=0, cfg_err=0, state IDLE, internal regs 0.
- start sampled at edge N -> out_valid=1 with pair (0,0) from edge N+1 (1-cycle latency).
- cfg_err asserted from edge N+1 for exactly one cycle when start rejected.
- Full throughput: with out_ready tied high, one pair per cycle; K pairs in cycles N+1..N+K, done in cycle N+K+1, IDLE at N+K+2, new start accepted at N+K+2.
- Index outputs registered; change only on an accepted handshake or state entry.
- Reset mid-block: immediate return to reset values, no done.

## Test plan
- K=40, f1=3, f2=10, out_ready=1 -> ilv_idx 0,13,6,19,12,... for i=0..4; 40 pairs, all ilv_idx distinct, last on i=39, done one cycle later.
- K=6144, f1=263, f2=480 -> final pair seq_idx=6143, ilv_idx=217, last=1; permutation check over all 6144 values; K=1056, f1=17, f2=66 -> final ilv_idx=49.
- K=40 with random out_ready toggling -> outputs hold while out_ready=0; sequence identical to full-rate run; no pair skipped or duplicated.
- start with k_len=30, or k_len=6145, or f1=k_len -> cfg_err one-cycle pulse, busy stays 0, out_valid stays 0.
- abort at i=10 of K=40 -> out_valid=0 next cycle, no done; subsequent start restarts at (0,0). Second start asserted during RUN -> ignored.
- reset asserted asynchronously mid-block -> all outputs 0 immediately; after release, start behaves as from power-up.

Source files
------------

// File: rtl/qpp_ind_gen.sv
// rtl/qpp_ind_gen.sv - QPP interleaver index generator
// Streams (i, (f1*i + f2*i^2) mod K) pairs using multiplier-free recursion.
module qpp_ind_gen #(
  parameter int ADDR_W = 14,
  parameter int MAX_K  = 6144,
  parameter int MIN_K  = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] k_len,
  input  logic [ADDR_W-1:0] f1,
  input  logic [ADDR_W-1:0] f2,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] seq_idx,
  output logic [ADDR_W-1:0] ilv_idx,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] k_r, k_n;
  logic [ADDR_W-1:0] seq_r, seq_n;
  logic [ADDR_W-1:0] pi_r, pi_n;
  logic [ADDR_W-1:0] g_r, g_n;
  logic [ADDR_W-1:0] d_r, d_n;
  logic              cfg_err_r, cfg_err_n;
  logic              cfg_ok;

  // Both operands are already reduced below m, so one conditional subtract suffices.
  function automatic logic [ADDR_W-1:0] add_mod(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] b,
                                                input logic [ADDR_W-1:0] m);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m})
      s = s - {1'b0, m};
    return s[ADDR_W-1:0];
  endfunction

  assign cfg_ok = (k_len >= ADDR_W'(MIN_K)) && (k_len <= ADDR_W'(MAX_K)) &&
                  (f1 < k_len) && (f2 < k_len);

  assign out_valid = (state == RUN);
  assign last      = out_valid && (seq_r == (k_r - ADDR_W'(1)));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign seq_idx   = seq_r;
  assign ilv_idx   = pi_r;
  assign cfg_err   = cfg_err_r;

  always_comb begin
    state_n   = state;
    k_n       = k_r;
    seq_n     = seq_r;
    pi_n      = pi_r;
    g_n       = g_r;
    d_n       = d_r;
    cfg_err_n = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              k_n     = k_len;
              seq_n   = '0;
              pi_n    = '0;
              g_n     = add_mod(f1, f2, k_len);
              d_n     = add_mod(f2, f2, k_len);
              state_n = RUN;
            end else begin
              cfg_err_n = 1'b1;
            end
          end
        end
        RUN: begin
          if (out_ready) begin
            if (last) begin
              state_n = DONE;
            end else begin
              seq_n = seq_r + ADDR_W'(1);
              pi_n  = add_mod(pi_r, g_r, k_r);
              g_n   = add_mod(g_r, d_r, k_r);
            end
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k_r       <= '0;
      seq_r     <= '0;
      pi_r      <= '0;
      g_r       <= '0;
      d_r       <= '0;
      cfg_err_r <= 1'b0;
    end else begin
      state     <= state_n;
      k_r       <= k_n;
      seq_r     <= seq_n;
      pi_r      <= pi_n;
      g_r       <= g_n;
      d_r       <= d_n;
      cfg_err_r <= cfg_err_n;
    end
  end

endmodule

// File: tb/tb_qpp_ind_gen.sv
// tb/tb_qpp_ind_gen.sv - directed self-checking bench for qpp_ind_gen
// Expected interleaved indices come from the closed-form QPP formula.
module tb_qpp_ind_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] k_len;
  logic [13:0] f1;
  logic [13:0] f2;
  logic        abort;
  logic        out_ready;
  logic        out_valid;
  logic [13:0] seq_idx;
  logic [13:0] ilv_idx;
  logic        last;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int checks   = 0;
  int failures = 0;

  qpp_ind_gen dut (
    .clock(clock), .reset(reset), .start(start), .k_len(k_len), .f1(f1), .f2(f2),
    .abort(abort), .out_ready(out_ready), .out_valid(out_valid), .seq_idx(seq_idx),
    .ilv_idx(ilv_idx), .last(last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: out_ready tied high; mode 1: random out_ready.
  // abort_at >= 0 aborts at that index; restart_at >= 0 pulses a stray start at that cycle.
  task automatic run_block(input int kk, input int ff1, input int ff2, input int mode,
                           input int abort_at, input int restart_at);
    bit          seen [6144];
    int          i, cyc, dup;
    longint      e;
    logic [31:0] exp_v;
    for (int j = 0; j < 6144; j++) seen[j] = 1'b0;
    start = 1'b1; k_len = 14'(kk); f1 = 14'(ff1); f2 = 14'(ff2);
    step();
    start = 1'b0;
    i = 0; cyc = 0; dup = 0;
    while (i < kk && cyc < 20000) begin
      out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (cyc == restart_at) begin
        start = 1'b1; k_len = 14'd50; f1 = 14'd1; f2 = 14'd0;
      end else begin
        start = 1'b0;
      end
      e = (longint'(ff1) * i + longint'(ff2) * i * i) % kk;
      exp_v = {2'b00, 1'b1, 1'(i == kk - 1), 14'(i), 14'(e)};
      chk("pair", {2'b00, out_valid, last, seq_idx, ilv_idx}, exp_v);
      if (i == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", {29'd0, out_valid, busy, done}, 32'd0);
        step();
        chk("abort_nodone", {30'd0, busy, done}, 32'd0);
        return;
      end
      if (out_ready) begin
        if (seen[ilv_idx]) dup++;
        seen[ilv_idx] = 1'b1;
        i++;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("all_pairs", 32'(i), 32'(kk));
    if (mode == 0) chk("throughput", 32'(cyc), 32'(kk));
    chk("distinct", 32'(dup), 32'd0);
    chk("done_pulse", {29'd0, done, out_valid, busy}, 32'b101);
    step();
    chk("idle_after", {29'd0, done, out_valid, busy}, 32'd0);
  endtask

  task automatic bad_cfg(input int kk, input int ff1, input int ff2);
    start = 1'b1; k_len = 14'(kk); f1 = 14'(ff1); f2 = 14'(ff2);
    step();
    start = 1'b0;
    chk("cfg_err_on", {29'd0, cfg_err, busy, out_valid}, 32'b100);
    step();
    chk("cfg_err_off", {29'd0, cfg_err, busy, out_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    k_len = '0; f1 = '0; f2 = '0;
    step(); step();
    chk("reset_state", {1'b0, out_valid, seq_idx, ilv_idx, last, busy, done, cfg_err}, 32'd0);
    reset = 1'b0;
    step();

    run_block(40, 3, 10, 0, -1, -1);
    run_block(6144, 263, 480, 0, -1, -1);
    run_block(1056, 17, 66, 0, -1, -1);
    run_block(40, 3, 10, 1, -1, 7);

    bad_cfg(30, 3, 10);
    bad_cfg(6145, 3, 10);
    bad_cfg(40, 40, 10);
    bad_cfg(40, 3, 40);

    run_block(40, 3, 10, 0, 10, -1);
    run_block(40, 3, 10, 0, -1, 5);

    // Asynchronous reset in the middle of a block.
    start = 1'b1; k_len = 14'd40; f1 = 14'd3; f2 = 14'd10;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("pre_reset_seq", 32'(seq_idx), 32'd3);
    #2 reset = 1'b1;
    #1 chk("async_reset", {1'b0, out_valid, seq_idx, ilv_idx, last, busy, done, cfg_err}, 32'd0);
    step();
    chk("reset_nodone", {30'd0, busy, done}, 32'd0);
    reset = 1'b0;
    step();
    run_block(1056, 17, 66, 1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
